// File: rtl/debug_led_pkg.sv
// Shared types and sizing helpers for the debug LED controller.
package debug_led_pkg;

   localparam int unsigned MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF         = 3'd0,
      MODE_ON          = 3'd1,
      MODE_LEVEL       = 3'd2,
      MODE_STRETCH     = 3'd3,
      MODE_BLINK       = 3'd4,
      MODE_BLINK_GATED = 3'd5,
      MODE_RSVD6       = 3'd6,
      MODE_RSVD7       = 3'd7
   } led_mode_t;

   // Width of a counter that must hold 0..ticks inclusive.
   function automatic int unsigned stretch_w(input int unsigned ticks);
      return (ticks < 1) ? 1 : $clog2(ticks + 1);
   endfunction

   // Width of a counter that must hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/debug_led_ctrl_channel.sv
// One LED channel: input synchroniser, activity stretcher, mode/duty registers
// and the registered pin driver.
module led_channel
   import debug_led_pkg::*;
#(
   parameter int unsigned STRETCH_TICKS = 50,
   parameter int unsigned PWM_W         = 4,
   parameter int unsigned ACTIVE_LOW    = 0,
   parameter int unsigned RESET_MODE    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_ch_in,
   input  logic             i_tick,
   input  logic             i_phase,
   input  logic [PWM_W-1:0] i_pwm_cnt,
   input  logic             i_cfg_wr,
   input  logic [2:0]       i_cfg_mode,
   input  logic [PWM_W-1:0] i_cfg_duty,
   output logic             o_led
);

   localparam int unsigned     CNT_W    = stretch_w(STRETCH_TICKS);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_TICKS);
   localparam led_mode_t       MODE_RST = led_mode_t'(MODE_W'(RESET_MODE));
   localparam logic            POL      = 1'(ACTIVE_LOW);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_sync_d;
   logic [CNT_W-1:0] r_cnt;
   led_mode_t        r_mode;
   logic [PWM_W-1:0] r_duty;
   logic             r_led;

   logic             w_edge;
   logic             w_raw_on;
   logic             w_pwm_on;

   // Two-flop synchroniser plus one delayed copy for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_sync_d <= 1'b0;
      end else begin
         r_sync1  <= i_ch_in;
         r_sync2  <= r_sync1;
         r_sync_d <= r_sync2;
      end
   end

   assign w_edge = r_sync2 & ~r_sync_d;

   // A config write clears the stretcher; otherwise an edge reloads it even on a tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_cfg_wr) begin
         r_cnt <= '0;
      end else if (w_edge) begin
         r_cnt <= CNT_LOAD;
      end else if (i_tick && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode <= MODE_RST;
         r_duty <= '1;
      end else if (i_cfg_wr) begin
         r_mode <= led_mode_t'(i_cfg_mode);
         r_duty <= i_cfg_duty;
      end
   end

   // Reserved modes fall through to the default and stay dark.
   always_comb begin
      w_raw_on = 1'b0;
      case (r_mode)
         MODE_ON:          w_raw_on = 1'b1;
         MODE_LEVEL:       w_raw_on = r_sync2;
         MODE_STRETCH:     w_raw_on = (r_cnt != '0);
         MODE_BLINK:       w_raw_on = i_phase;
         MODE_BLINK_GATED: w_raw_on = i_phase & r_sync2;
         default:          w_raw_on = 1'b0;
      endcase
   end

   assign w_pwm_on = (r_duty == '1) | (i_pwm_cnt < r_duty);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_led <= POL;
      end else begin
         r_led <= (w_raw_on & w_pwm_on) ^ POL;
      end
   end

   assign o_led = r_led;

endmodule

// File: rtl/debug_led_ctrl.sv
// Multi-channel debug LED controller: shared tick prescaler, blink phase and
// PWM counter, config decode, and one led_channel per output pin.
module debug_led_ctrl
   import debug_led_pkg::*;
#(
   parameter int unsigned NUM_CH        = 8,
   parameter int unsigned TICK_DIV      = 27000,
   parameter int unsigned BLINK_TICKS   = 300,
   parameter int unsigned STRETCH_TICKS = 50,
   parameter int unsigned PWM_W         = 4,
   parameter int unsigned ACTIVE_LOW    = 0,
   parameter int unsigned RESET_MODE    = 2
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_CH-1:0]                      ch_in,
   input  logic                                   cfg_wr,
   input  logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0] cfg_ch,
   input  logic [2:0]                             cfg_mode,
   input  logic [PWM_W-1:0]                       cfg_duty,
   output logic [NUM_CH-1:0]                      led_out,
   output logic                                   tick_out,
   output logic                                   heartbeat_out
);

   localparam int unsigned CH_W  = $clog2(NUM_CH > 1 ? NUM_CH : 2);
   localparam int unsigned PRE_W = cnt_w(TICK_DIV);
   localparam int unsigned BLK_W = cnt_w(BLINK_TICKS);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_TICKS - 1);

   logic [PRE_W-1:0] r_pre;
   logic             r_tick;
   logic [BLK_W-1:0] r_blk;
   logic             r_phase;
   logic [PWM_W-1:0] r_pwm_cnt;

   logic [PRE_W-1:0] w_pre_nxt;
   logic             w_cfg_ok;
   logic [NUM_CH-1:0] w_ch_wr;
   logic [NUM_CH-1:0] w_led;

   assign w_pre_nxt = (r_pre == PRE_LAST) ? '0 : r_pre + PRE_W'(1);

   // The tick flag is registered alongside the count so it is high exactly
   // while the count sits at its last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_pre  <= w_pre_nxt;
         r_tick <= (w_pre_nxt == PRE_LAST);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blk   <= '0;
         r_phase <= 1'b0;
      end else if (r_tick) begin
         if (r_blk == BLK_LAST) begin
            r_blk   <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_blk <= r_blk + BLK_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      end
   end

   // Writes addressed past the last channel are dropped.
   assign w_cfg_ok = cfg_wr & ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign w_ch_wr[i] = w_cfg_ok & (cfg_ch == CH_W'(i));

      led_channel #(
         .STRETCH_TICKS (STRETCH_TICKS),
         .PWM_W         (PWM_W),
         .ACTIVE_LOW    (ACTIVE_LOW),
         .RESET_MODE    (RESET_MODE)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_ch_in    (ch_in[i]),
         .i_tick     (r_tick),
         .i_phase    (r_phase),
         .i_pwm_cnt  (r_pwm_cnt),
         .i_cfg_wr   (w_ch_wr[i]),
         .i_cfg_mode (cfg_mode),
         .i_cfg_duty (cfg_duty),
         .o_led      (w_led[i])
      );
   end

   assign led_out       = w_led;
   assign tick_out      = r_tick;
   assign heartbeat_out = r_phase;

endmodule
